image_swap_irq_ctrl: RTL

Multi-channel, double-buffered image-update controller for the ZCU104 HDMI image path. It sits between the AXI register slave and the per-channel image buffers. It raises an interrupt when a new image is requested, either by an external `image_change` pulse or by a software command. It then counts the host's data-buffer writes into the shadow bank, and swaps banks on the next display frame boundary once the host signals data done. It generalises the single-channel IRQ/data-done flow to `N_CH` channels, with per-channel image size, IRQ masking, deferred requests and error flags.

---
 rtl/image_swap_irq_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/image_swap_irq_ctrl.sv
// Multi-channel double-buffered image-update controller: raises per-channel IRQs on new-image
// requests, steers host data beats into the shadow bank and swaps banks on the next frame boundary.
module image_swap_irq_ctrl #(
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12
) (
  input  logic              s_axi_aclk,
  input  logic              reset,
  input  logic              reg_wr_en,
  input  logic [3:0]        reg_wr_addr,
  input  logic [CH_W-1:0]   reg_wr_ch,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic [N_CH-1:0]   image_change,
  input  logic              frame_start,
  output logic              buf_wr_en,
  output logic [CH_W-1:0]   buf_wr_ch,
  output logic [ADDR_W:0]   buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic [N_CH-1:0]   irq_status,
  output logic              irq_signal,
  output logic [N_CH-1:0]   active_bank,
  output logic [N_CH-1:0]   swap,
  output logic [N_CH-1:0]   error
);

  localparam logic [3:0] CMD_SET_SIZE    = 4'd0;
  localparam logic [3:0] CMD_WRITE_DATA  = 4'd1;
  localparam logic [3:0] CMD_DATA_DONE   = 4'd2;
  localparam logic [3:0] CMD_NEW_IMAGE   = 4'd3;
  localparam logic [3:0] CMD_DEASSERT    = 4'd4;
  localparam logic [3:0] CMD_IRQ_ENABLE  = 4'd5;
  localparam logic [3:0] CMD_CLEAR_ERROR = 4'd6;

  localparam logic [ADDR_W:0] MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ARMED = 2'd3
  } state_t;

  state_t            state_r [N_CH];
  logic [ADDR_W:0]   cnt_r   [N_CH];
  logic [ADDR_W:0]   size_r  [N_CH];
  logic [N_CH-1:0]   defer_r;
  logic [N_CH-1:0]   irq_enable_r;
  logic [N_CH-1:0]   sync1_r;
  logic [N_CH-1:0]   sync2_r;
  logic [N_CH-1:0]   sync3_r;

  logic [N_CH-1:0]   trig_hw_s;
  logic [N_CH-1:0]   trig_s;
  logic [N_CH-1:0]   sel_s;
  logic              is_size_s;
  logic              is_write_s;
  logic              is_done_s;
  logic              is_new_s;
  logic              is_deassert_s;
  logic              is_enable_s;
  logic              is_clear_s;
  logic [ADDR_W:0]   size_sat_s;

  assign irq_signal = |(irq_status & irq_enable_r);

  // Command decode, request merging and image-size saturation.
  always_comb begin
    trig_hw_s     = sync2_r & ~sync3_r;
    is_size_s     = reg_wr_en && (reg_wr_addr == CMD_SET_SIZE);
    is_write_s    = reg_wr_en && (reg_wr_addr == CMD_WRITE_DATA);
    is_done_s     = reg_wr_en && (reg_wr_addr == CMD_DATA_DONE);
    is_new_s      = reg_wr_en && (reg_wr_addr == CMD_NEW_IMAGE);
    is_deassert_s = reg_wr_en && (reg_wr_addr == CMD_DEASSERT);
    is_enable_s   = reg_wr_en && (reg_wr_addr == CMD_IRQ_ENABLE);
    is_clear_s    = reg_wr_en && (reg_wr_addr == CMD_CLEAR_ERROR);
    sel_s         = {N_CH{1'b0}};
    for (int ch = 0; ch < N_CH; ch++) begin
      sel_s[ch] = reg_wr_en && (reg_wr_ch == CH_W'(ch));
    end
    trig_s = trig_hw_s | (sel_s & {N_CH{is_new_s}});
    if (reg_wr_data[ADDR_W:0] > MAX_SIZE) begin
      size_sat_s = MAX_SIZE;
    end else begin
      size_sat_s = reg_wr_data[ADDR_W:0];
    end
  end

  // Synchronizers, per-channel FSMs, bank control and buffer write port.
  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      sync1_r      <= {N_CH{1'b0}};
      sync2_r      <= {N_CH{1'b0}};
      sync3_r      <= {N_CH{1'b0}};
      irq_enable_r <= {N_CH{1'b1}};
      defer_r      <= {N_CH{1'b0}};
      irq_status   <= {N_CH{1'b0}};
      active_bank  <= {N_CH{1'b0}};
      swap         <= {N_CH{1'b0}};
      error        <= {N_CH{1'b0}};
      buf_wr_en    <= 1'b0;
      buf_wr_ch    <= {CH_W{1'b0}};
      buf_wr_addr  <= {(ADDR_W+1){1'b0}};
      buf_wr_data  <= {DATA_W{1'b0}};
      for (int ch = 0; ch < N_CH; ch++) begin
        state_r[ch] <= ST_IDLE;
        cnt_r[ch]   <= {(ADDR_W+1){1'b0}};
        size_r[ch]  <= {(ADDR_W+1){1'b0}};
      end
    end else begin
      sync1_r   <= image_change;
      sync2_r   <= sync1_r;
      sync3_r   <= sync2_r;
      buf_wr_en <= 1'b0;
      if (is_enable_s) begin
        irq_enable_r <= reg_wr_data[N_CH-1:0];
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        swap[ch] <= 1'b0;
        case (state_r[ch])
          ST_IDLE: begin
            // A fresh trigger and a deferred one collapse into a single request.
            if (trig_s[ch] || defer_r[ch]) begin
              state_r[ch]    <= ST_REQ;
              irq_status[ch] <= 1'b1;
              defer_r[ch]    <= 1'b0;
            end
            if (sel_s[ch] && (is_write_s || is_done_s || is_deassert_s)) begin
              error[ch] <= 1'b1;
            end
          end
          ST_REQ: begin
            if (sel_s[ch] && is_deassert_s) begin
              state_r[ch]    <= ST_LOAD;
              irq_status[ch] <= 1'b0;
              cnt_r[ch]      <= {(ADDR_W+1){1'b0}};
              if (trig_s[ch]) begin
                defer_r[ch] <= 1'b1;
              end
            end
            if (sel_s[ch] && (is_write_s || is_done_s)) begin
              error[ch] <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (trig_s[ch]) begin
              defer_r[ch] <= 1'b1;
            end
            if (sel_s[ch] && is_write_s) begin
              if (cnt_r[ch] < size_r[ch]) begin
                buf_wr_en   <= 1'b1;
                buf_wr_ch   <= reg_wr_ch;
                buf_wr_addr <= {~active_bank[ch], cnt_r[ch][ADDR_W-1:0]};
                buf_wr_data <= reg_wr_data;
                cnt_r[ch]   <= cnt_r[ch] + CNT_ONE;
              end else begin
                error[ch] <= 1'b1;
              end
            end
            if (sel_s[ch] && is_done_s) begin
              if (cnt_r[ch] == size_r[ch]) begin
                state_r[ch] <= ST_ARMED;
              end else begin
                error[ch]   <= 1'b1;
                state_r[ch] <= ST_IDLE;
              end
            end
            if (sel_s[ch] && is_deassert_s) begin
              error[ch] <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (trig_s[ch]) begin
              defer_r[ch] <= 1'b1;
            end
            if (frame_start) begin
              state_r[ch]     <= ST_IDLE;
              swap[ch]        <= 1'b1;
              active_bank[ch] <= ~active_bank[ch];
            end
            if (sel_s[ch] && (is_write_s || is_done_s || is_deassert_s)) begin
              error[ch] <= 1'b1;
            end
          end
          default: begin
            state_r[ch] <= ST_IDLE;
          end
        endcase
        if (sel_s[ch] && is_size_s) begin
          if (state_r[ch] == ST_IDLE) begin
            size_r[ch] <= size_sat_s;
          end else begin
            error[ch] <= 1'b1;
          end
        end
        if (sel_s[ch] && is_clear_s) begin
          error[ch] <= 1'b0;
        end
      end
    end
  end

endmodule
